// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: two-entry ID/EX skid buffer whose held operands track write-back bypass.
module id_ex_skid_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 64,
  parameter int AW     = 5,
  parameter int NUM_WB = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [XLEN-1:0]        in_pc_i,
  input  logic [CTRL_W-1:0]      in_ctrl_i,
  input  logic [AW-1:0]          in_rs1_addr_i,
  input  logic [AW-1:0]          in_rs2_addr_i,
  input  logic [XLEN-1:0]        in_rs1_data_i,
  input  logic [XLEN-1:0]        in_rs2_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        out_pc_o,
  output logic [CTRL_W-1:0]      out_ctrl_o,
  output logic [AW-1:0]          out_rs1_addr_o,
  output logic [AW-1:0]          out_rs2_addr_o,
  output logic [XLEN-1:0]        out_rs1_data_o,
  output logic [XLEN-1:0]        out_rs2_data_o,
  input  logic                   flush_i,
  output logic [1:0]             occupancy_o,
  input  logic [NUM_WB-1:0]      wb_wren_i,
  input  logic [NUM_WB*AW-1:0]   wb_addr_i,
  input  logic [NUM_WB*XLEN-1:0] wb_data_i
);
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [AW-1:0]     rs1_addr;
    logic [AW-1:0]     rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
  } entry_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state;
  entry_t main_q, skid_q, in_e;
  logic accept, pop;
  // Highest-numbered matching port wins; x0 is never forwarded.
  function automatic logic [XLEN-1:0] byp(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    byp = d;
    for (int k = 0; k < NUM_WB; k++)
      if (wb_wren_i[k] && wb_addr_i[k*AW +: AW] == a && a != '0) byp = wb_data_i[k*XLEN +: XLEN];
  endfunction
  function automatic entry_t fwd(input entry_t e);
    fwd = e;
    fwd.rs1_data = byp(e.rs1_addr, e.rs1_data);
    fwd.rs2_data = byp(e.rs2_addr, e.rs2_data);
  endfunction
  assign in_e = '{pc: in_pc_i, ctrl: in_ctrl_i, rs1_addr: in_rs1_addr_i, rs2_addr: in_rs2_addr_i,
                  rs1_data: in_rs1_data_i, rs2_data: in_rs2_data_i};
  assign in_ready_o     = state != TWO;
  assign out_valid_o    = state != EMPTY;
  assign occupancy_o    = state;
  assign accept         = in_valid_i && in_ready_o;
  assign pop            = out_valid_o && out_ready_i;
  assign out_pc_o       = main_q.pc;
  assign out_ctrl_o     = main_q.ctrl;
  assign out_rs1_addr_o = main_q.rs1_addr;
  assign out_rs2_addr_o = main_q.rs2_addr;
  assign out_rs1_data_o = main_q.rs1_data;
  assign out_rs2_data_o = main_q.rs2_data;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      state <= EMPTY;
    end else begin
      main_q <= (accept && (state == EMPTY || pop)) ? fwd(in_e) :
                (state == TWO && pop)               ? fwd(skid_q) : fwd(main_q);
      skid_q <= (state == ONE && accept && !pop) ? fwd(in_e) : fwd(skid_q);
      state  <= state == EMPTY ? (accept ? ONE : EMPTY) :
                state == ONE   ? ((accept && !pop) ? TWO : (!accept && pop) ? EMPTY : ONE) :
                                 (pop ? ONE : TWO);
    end
  end
endmodule

// File: tb/tb_id_ex_skid_stage.sv
// tb_id_ex_skid_stage: directed scenarios plus random traffic against a queue-based model.
module tb_id_ex_skid_stage;
  logic clk = 0, rst_ni = 0;
  logic in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] in_pc, in_d1, in_d2, out_pc, out_d1, out_d2;
  logic [63:0] in_ctrl, out_ctrl;
  logic [4:0] in_a1, in_a2, out_a1, out_a2;
  logic [1:0] occ, wb_wren;
  logic [9:0] wb_addr;
  logic [63:0] wb_data;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] pc;
    logic [63:0] ctrl;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  id_ex_skid_stage #(.XLEN(32), .CTRL_W(64), .AW(5), .NUM_WB(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_pc_i(in_pc), .in_ctrl_i(in_ctrl),
    .in_rs1_addr_i(in_a1), .in_rs2_addr_i(in_a2), .in_rs1_data_i(in_d1), .in_rs2_data_i(in_d2),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc), .out_ctrl_o(out_ctrl),
    .out_rs1_addr_o(out_a1), .out_rs2_addr_o(out_a2), .out_rs1_data_o(out_d1), .out_rs2_data_o(out_d2),
    .flush_i(flush), .occupancy_o(occ),
    .wb_wren_i(wb_wren), .wb_addr_i(wb_addr), .wb_data_i(wb_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_byp(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] r = d;
    for (int k = 0; k < 2; k++)
      if (wb_wren[k] && wb_addr[k*5 +: 5] == a && a != 0) r = wb_data[k*32 +: 32];
    return r;
  endfunction

  task automatic compare();
    chk("valid", out_valid, q.size() > 0);
    chk("ready", in_ready, q.size() < 2);
    chk("occ", occ, q.size());
    if (q.size() > 0) begin
      chk("pc", out_pc, q[0].pc);
      chk("ctrl", out_ctrl, q[0].ctrl);
      chk("rs1_addr", out_a1, q[0].a1);
      chk("rs2_addr", out_a2, q[0].a2);
      chk("rs1_data", out_d1, q[0].d1);
      chk("rs2_data", out_d2, q[0].d2);
    end
  endtask

  // Advance one clock and update the model from the inputs sampled at that edge.
  task automatic tick();
    bit acc, pop;
    ent_t e;
    @(posedge clk);
    acc = in_valid && q.size() < 2;
    pop = q.size() > 0 && out_ready;
    if (flush) q.delete();
    else begin
      foreach (q[i]) begin
        q[i].d1 = model_byp(q[i].a1, q[i].d1);
        q[i].d2 = model_byp(q[i].a2, q[i].d2);
      end
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.pc = in_pc; e.ctrl = in_ctrl; e.a1 = in_a1; e.a2 = in_a2;
        e.d1 = model_byp(in_a1, in_d1); e.d2 = model_byp(in_a2, in_d2);
        q.push_back(e);
      end
    end
    #1 compare();
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] a2, input logic [31:0] d2);
    in_valid = 1; in_pc = pc; in_ctrl = {pc, ~pc}; in_a1 = a1; in_d1 = d1; in_a2 = a2; in_d2 = d2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_occ"}, occ, 0);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_ctrl"}, out_ctrl, 0);
    chk({tag, "_data"}, {out_d1, out_d2}, 0);
    chk({tag, "_addr"}, {out_a1, out_a2}, 0);
  endtask

  initial begin
    in_valid = 0; out_ready = 0; flush = 0; wb_wren = 0; wb_addr = 0; wb_data = 0;
    push(0, 0, 0, 0, 0); in_valid = 0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_ni = 1;
    // Streaming at full throughput
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      push(32'(4 * i), 1, 32'h100 + 32'(i), 2, 32'h200);
      tick();
      chk("stream_pc", out_pc, 64'(4 * i));
      chk("stream_occ", occ, 1);
    end
    in_valid = 0; tick();
    // Backpressure
    out_ready = 0;
    push(32'h10, 1, 1, 2, 2); tick();
    push(32'h14, 1, 1, 2, 2); tick();
    chk("bp_occ", occ, 2);
    chk("bp_ready", in_ready, 0);
    push(32'h18, 1, 1, 2, 2); tick();
    chk("bp_hold_pc", out_pc, 32'h10);
    out_ready = 1; tick();
    chk("bp_rel1", out_pc, 32'h14);
    tick();
    chk("bp_rel2", out_pc, 32'h18);
    in_valid = 0; tick();
    chk("bp_drain", out_valid, 0);
    // Held bypass while stalled, x0 never forwarded
    out_ready = 0;
    push(32'h20, 5, 32'h1111, 0, 32'h2222); tick();
    in_valid = 0; tick();
    chk("held_pre", out_d1, 32'h1111);
    wb_wren = 2'b01; wb_addr = {5'd0, 5'd5}; wb_data = {32'h0, 32'hABCD}; tick();
    chk("held_byp", out_d1, 32'hABCD);
    wb_addr = {5'd0, 5'd0}; wb_data = {32'h0, 32'hDEAD}; tick();
    chk("x0_rs2", out_d2, 32'h2222);
    chk("x0_rs1", out_d1, 32'hABCD);
    wb_wren = 0; out_ready = 1; tick();
    // Multi-port priority at capture
    push(32'h30, 0, 0, 7, 32'h1234);
    wb_wren = 2'b11; wb_addr = {5'd7, 5'd7}; wb_data = {32'hBBBB, 32'hAAAA}; tick();
    chk("prio_rs2", out_d2, 32'hBBBB);
    wb_wren = 0; in_valid = 0; tick();
    // Flush in TWO with a concurrent valid input
    out_ready = 0;
    push(32'h40, 1, 1, 1, 1); tick();
    push(32'h44, 1, 1, 1, 1); tick();
    chk("fl_pre_occ", occ, 2);
    flush = 1; push(32'h48, 1, 1, 1, 1); tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_occ", occ, 0);
    chk("fl_ready", in_ready, 1);
    flush = 0; in_valid = 0; tick();
    chk("fl_nocap", out_valid, 0);
    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 31) == 0;
      in_pc = $urandom; in_ctrl = {$urandom, $urandom};
      in_a1 = 5'($urandom_range(0, 7)); in_a2 = 5'($urandom_range(0, 7));
      in_d1 = $urandom; in_d2 = $urandom;
      wb_wren = 2'($urandom);
      wb_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wb_data = {$urandom, $urandom};
      tick();
    end
    flush = 0; wb_wren = 0;
    // Asynchronous reset mid-cycle in TWO
    out_ready = 0;
    push(32'h50, 3, 3, 4, 4); tick();
    push(32'h54, 3, 3, 4, 4); tick();
    chk("ar_pre_occ", occ, 2);
    #2 rst_ni = 0;
    #1 check_zero("async_rst");
    q.delete();
    @(negedge clk) rst_ni = 1;
    push(32'h60, 1, 32'h77, 2, 32'h88); out_ready = 1; tick();
    chk("post_rst_pc", out_pc, 32'h60);
    chk("post_rst_occ", occ, 1);
    in_valid = 0; tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
